// File: rtl/meiniki_pi_pkg.sv
// ============================================================================
// Module  : meiniki_pi_pkg
// Brief   : Shared digit codes and pacer state encoding for the pi display path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package meiniki_pi_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_DOT   = 4'hA;
  localparam digit_t DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } pacer_state_t;

endpackage

`default_nettype wire

// File: rtl/meiniki_digit_pacer_if.sv
// ============================================================================
// Module  : meiniki_digit_pacer_if
// Brief   : Digit stream in (ready/valid) and paced display outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface meiniki_digit_pacer_if;
  import meiniki_pi_pkg::*;

  digit_t digit_in;
  logic   digit_valid;
  logic   digit_ready;
  digit_t digit_out;
  logic   blank;
  logic   shown;

  modport master (
    output digit_in, digit_valid,
    input  digit_ready, digit_out, blank, shown
  );

  modport slave (
    input  digit_in, digit_valid,
    output digit_ready, digit_out, blank, shown
  );
endinterface

`default_nettype wire

// File: rtl/meiniki_pace_cnt.sv
// ============================================================================
// Module  : meiniki_pace_cnt
// Brief   : Loadable down-counter with a "value == 1" flag for digit pacing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module meiniki_pace_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign last  = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/meiniki_digit_pacer.sv
// ============================================================================
// Module  : meiniki_digit_pacer
// Brief   : Holds each streamed digit on the display for HOLD_CYCLES clocks,
//           optionally preceded by GAP_CYCLES blank clocks.
//           Define MEINIKI_PACER_DUPGAP_EN to blank only between repeated digits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module meiniki_digit_pacer
  import meiniki_pi_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  meiniki_digit_pacer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam bit               GAP_ON  = (GAP_CYCLES > 0);

  pacer_state_t     state_q, state_d;
  digit_t           digit_q, digit_d;
  digit_t           last_digit_q, last_digit_d;
  logic             last_valid_q, last_valid_d;
  logic             shown_q, shown_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  logic             ready;
  logic             xfer;
  logic             gap_req;

  meiniki_pace_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .last     (cnt_last)
  );

  assign ready = (state_q == IDLE) || ((state_q == SHOW) && cnt_last);
  assign xfer  = bus.digit_valid && ready;

`ifdef MEINIKI_PACER_DUPGAP_EN
  // last_digit_q still holds the digit on display when a back-to-back accept happens
  assign gap_req = last_valid_q && (bus.digit_in == last_digit_q);
`else
  assign gap_req = 1'b1;
`endif

  // Counter parks at zero once the pacer has gone idle
  assign cnt_dec = (state_q != IDLE) && (cnt_value != '0);

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    last_digit_d = last_digit_q;
    last_valid_d = last_valid_q;
    shown_d      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LD;

    unique case (state_q)
      IDLE, SHOW: begin
        if ((state_q == IDLE) || cnt_last) begin
          if (xfer) begin
            digit_d  = bus.digit_in;
            cnt_load = 1'b1;
            if (gap_req && GAP_ON) begin
              state_d      = GAP;
              cnt_load_val = GAP_LD;
            end else begin
              state_d      = SHOW;
              shown_d      = 1'b1;
              last_digit_d = bus.digit_in;
              last_valid_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_last) begin
          state_d      = SHOW;
          cnt_load     = 1'b1;
          shown_d      = 1'b1;
          last_digit_d = digit_q;
          last_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      digit_q      <= DIGIT_BLANK;
      last_digit_q <= DIGIT_BLANK;
      last_valid_q <= 1'b0;
      shown_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      last_digit_q <= last_digit_d;
      last_valid_q <= last_valid_d;
      shown_q      <= shown_d;
    end
  end

  assign bus.digit_ready = ready;
  assign bus.digit_out   = (state_q == SHOW) ? digit_q : DIGIT_BLANK;
  assign bus.blank       = (state_q != SHOW);
  assign bus.shown       = shown_q;

endmodule

`default_nettype wire

// File: doc/meiniki_digit_pacer.md
Name: meiniki_digit_pacer

Overview:
Sits between the pi digit generator (digit index counter plus densely-packed-decimal expansion) and the 7-segment decoder. It takes a ready/valid stream of 4-bit digit codes and holds each digit on the display for a programmable number of clocks. A blank gap can be inserted between digits so that repeated digits (e.g. "3 3") stay visually distinct. Its ready output replaces the free-running index advance, so the generator only steps when the display has consumed a digit.

Parameters:
HOLD_CYCLES, 8, number of clocks each accepted digit is displayed; must be >= 1.
GAP_CYCLES, 2, number of blank clocks inserted before a digit when a gap is required; 0 disables gaps entirely.
CNT_W, 4, width of the internal pacing counter; must satisfy 2**CNT_W > max(HOLD_CYCLES, GAP_CYCLES).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
digit_in  input  4  digit code: 0-9 decimal, 4'hA = decimal point, others passed through unchanged.
digit_valid  input  1  digit_in is valid.
digit_ready  output  1  pacer accepts digit_in this cycle.
digit_out  output  4  code to the 7-segment decoder; 4'hF while blank.
blank  output  1  1 during IDLE and GAP.
shown  output  1  one-cycle pulse on the first SHOW cycle of each digit.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE, counter=0, digit register=4'hF, last-digit-valid flag=0, digit_out=4'hF, blank=1, shown=0.
- Handshake rules:
  - A transfer occurs on a rising edge with digit_valid & digit_ready & ~reset.
  - digit_ready is combinational from the registered state: 1 in IDLE; 1 in SHOW when counter==1 (last hold cycle); 0 otherwise.
  - digit_in and digit_valid are ignored while reset is high.
- FSM states: IDLE, GAP, SHOW. Counters count down to 1.
  - IDLE: blank output. On transfer, capture digit_in.
    - Gap required and GAP_CYCLES>0: go to GAP, counter=GAP_CYCLES.
    - Otherwise: go to SHOW, counter=HOLD_CYCLES.
  - GAP: blank output; decrement counter. At counter==1, go to SHOW with counter=HOLD_CYCLES.
  - SHOW: digit_out=captured digit, blank=0; decrement counter. At counter==1:
    - With a transfer: capture the new digit and branch exactly as from IDLE (back-to-back, no idle cycle).
    - Without a transfer: go to IDLE.
- On entry to SHOW, the last-digit register is set to the shown digit and the last-digit-valid flag is set to 1.
- shown=1 exactly on the first cycle of each SHOW period, including back-to-back re-entry.
- Latency: a digit accepted at edge t appears on digit_out at edge t+1 (no gap) or at t+1+GAP_CYCLES (with gap).
- All outputs are registered, or decoded only from registered state.
- Reset mid-operation: asynchronously return to IDLE, discard the captured digit, clear the last-digit-valid flag.
- Boundary cases:
  - HOLD_CYCLES=1: digit_ready is high on every SHOW cycle.
  - digit_in=4'hF: accepted and displayed as 4'hF with blank=0.

Optional Feature:
Macro: MEINIKI_PACER_DUPGAP_EN.
- Defined: a gap is required only when last-digit-valid=1 and the captured digit equals the last shown digit.
- Undefined: a gap is required before every digit, including the first after reset.

Decomposition:
- Package meiniki_pi_pkg:
  - constants DIGIT_DOT=4'hA and DIGIT_BLANK=4'hF;
  - 2-bit state typedef pacer_state_t {IDLE, GAP, SHOW};
  - digit code typedef digit_t (logic [3:0]).
- Natural sub-module: meiniki_pace_cnt, a loadable CNT_W down-counter with load, value and last (==1) flag.
- FSM and digit registers stay in meiniki_digit_pacer.

Test Plan:
All scenarios use HOLD_CYCLES=3 and GAP_CYCLES=2 unless stated otherwise.
1. Assert reset with digit_valid=1 -> digit_out=4'hF, blank=1, shown=0, digit_ready=1, no capture. Release -> first accept on the next edge.
2. Macro off, constant valid stream 3,A,1,4 -> each digit: 2 blank cycles then 3 SHOW cycles; accepts every 5 cycles; shown pulses at cycles 3, 8, 13, 18 after the first accept.
3. Macro on, stream 1,5,9 -> no blank cycles, each digit shown 3 cycles back-to-back. Stream 1,1 -> exactly 2 blank cycles between the two 1s.
4. Drop digit_valid during SHOW of 7 -> after 3 cycles go to IDLE (blank=1, digit_ready=1). Raise valid with 2 -> accepted that edge; 2 shown after GAP (macro off).
5. Macro on, show 5, assert reset in its second SHOW cycle -> digit_out=4'hF immediately. After release, send 5 -> shown with no gap (last-digit-valid cleared).
6. GAP_CYCLES=0, macro off, stream 8,8 -> blank never asserted after the first accept; each 8 shown 3 cycles.
